// File: rtl/debug_pkg.sv
// Shared definitions for the host debug command decoder: opcodes,
// acknowledge codes, FSM state encoding and small decode helpers.
package debug_pkg;

  // Decoder FSM states
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR_HI  = 4'd1,
    ST_ADDR_LO  = 4'd2,
    ST_LEN      = 4'd3,
    ST_DATA     = 4'd4,
    ST_ISSUE    = 4'd5,
    ST_WAIT_CMP = 4'd6,
    ST_CLEAR    = 4'd7,
    ST_ACK      = 4'd8
  } state_e;

  // Host opcodes (first byte of every frame)
  localparam logic [7:0] OP_RUN     = 8'h01;
  localparam logic [7:0] OP_HALT    = 8'h02;
  localparam logic [7:0] OP_STEP    = 8'h03;
  localparam logic [7:0] OP_PROGRAM = 8'h10;
  localparam logic [7:0] OP_CLEAR   = 8'h20;

  // Acknowledge codes that are not an echo of the opcode
  localparam logic [7:0] ACK_UNKNOWN = 8'hEE;
  localparam logic [7:0] ACK_TIMEOUT = 8'hEF;

  // States in which a host byte may be consumed
  function automatic logic accepts_rx(state_e s);
    return (s == ST_IDLE) || (s == ST_ADDR_HI) || (s == ST_ADDR_LO) ||
           (s == ST_LEN) || (s == ST_DATA);
  endfunction

  // PROGRAM length byte: zero encodes a full 256-byte burst
  function automatic logic [8:0] frame_len(logic [7:0] b);
    return (b == 8'h00) ? 9'd256 : {1'b0, b};
  endfunction

  // Opcodes forwarded to the harness FSM
  function automatic logic is_harness_op(logic [7:0] op);
    return (op == OP_RUN) || (op == OP_HALT) || (op == OP_STEP);
  endfunction

endpackage

// File: rtl/debug_cmd_decoder.sv
// Host debug command decoder: parses byte frames from the serial receiver,
// drives harness commands, code-ROM writes/clears and returns one
// acknowledge byte per frame. Every output comes straight from a register.
module debug_cmd_decoder
  import debug_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [3:0]  debug_cmd,
  input  logic        command_complete,
  output logic [11:0] code_rom_addr_out,
  output logic [7:0]  code_rom_data_out,
  output logic        program_rom_mode,
  output logic        code_rom_clr_n
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [7:0]    opcode_q, opcode_d;
  logic [11:0]   addr_q, addr_d;
  logic [8:0]    len_q, len_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          rx_ready_q, rx_ready_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [11:0]   rom_addr_q, rom_addr_d;
  logic [7:0]    rom_data_q, rom_data_d;
  logic          rom_wr_q, rom_wr_d;
  logic          clr_n_q, clr_n_d;
  logic          rx_fire;

  assign rx_fire = rx_valid && rx_ready_q;

  // Next-state and next-output decode for the frame parser
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    addr_d     = addr_q;
    len_d      = len_q;
    tmo_d      = tmo_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    rom_addr_d = rom_addr_q;
    rom_data_d = rom_data_q;
    cmd_d      = '0;
    rom_wr_d   = 1'b0;
    clr_n_d    = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          opcode_d = rx_data;
          if (is_harness_op(rx_data)) begin
            state_d = ST_ISSUE;
            cmd_d   = rx_data[3:0];
          end else if (rx_data == OP_PROGRAM) begin
            state_d = ST_ADDR_HI;
          end else if (rx_data == OP_CLEAR) begin
            state_d = ST_CLEAR;
            clr_n_d = 1'b0;
          end else begin
            state_d    = ST_ACK;
            tx_valid_d = 1'b1;
            tx_data_d  = ACK_UNKNOWN;
          end
        end
      end
      ST_ADDR_HI: begin
        if (rx_fire) begin
          addr_d[11:8] = rx_data[3:0];
          state_d      = ST_ADDR_LO;
        end
      end
      ST_ADDR_LO: begin
        if (rx_fire) begin
          addr_d[7:0] = rx_data;
          state_d     = ST_LEN;
        end
      end
      ST_LEN: begin
        if (rx_fire) begin
          len_d   = frame_len(rx_data);
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // The strobe cycle of the final byte is spent in DATA so the ack
        // is raised only after the last write has been presented.
        if (rom_wr_q) begin
          if (len_q == '0) begin
            state_d    = ST_ACK;
            tx_valid_d = 1'b1;
            tx_data_d  = OP_PROGRAM;
          end
        end else if (rx_fire) begin
          rom_wr_d   = 1'b1;
          rom_addr_d = addr_q;
          rom_data_d = rx_data;
          addr_d     = addr_q + 12'd1;
          len_d      = len_q - 9'd1;
        end
      end
      ST_ISSUE: begin
        tmo_d   = '0;
        state_d = ST_WAIT_CMP;
      end
      ST_WAIT_CMP: begin
        if (command_complete) begin
          state_d    = ST_ACK;
          tx_valid_d = 1'b1;
          tx_data_d  = opcode_q;
        end else if (tmo_q == TMO_LAST) begin
          state_d    = ST_ACK;
          tx_valid_d = 1'b1;
          tx_data_d  = ACK_TIMEOUT;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
      end
      ST_CLEAR: begin
        state_d    = ST_ACK;
        tx_valid_d = 1'b1;
        tx_data_d  = OP_CLEAR;
      end
      ST_ACK: begin
        if (tx_ready) begin
          state_d    = ST_IDLE;
          tx_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase

    rx_ready_d = accepts_rx(state_d) && !rom_wr_d;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      opcode_q   <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      tmo_q      <= '0;
      rx_ready_q <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      cmd_q      <= '0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
      rom_wr_q   <= 1'b0;
      clr_n_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      tmo_q      <= tmo_d;
      rx_ready_q <= rx_ready_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      cmd_q      <= cmd_d;
      rom_addr_q <= rom_addr_d;
      rom_data_q <= rom_data_d;
      rom_wr_q   <= rom_wr_d;
      clr_n_q    <= clr_n_d;
    end
  end

  assign rx_ready          = rx_ready_q;
  assign tx_data           = tx_data_q;
  assign tx_valid          = tx_valid_q;
  assign debug_cmd         = cmd_q;
  assign code_rom_addr_out = rom_addr_q;
  assign code_rom_data_out = rom_data_q;
  assign program_rom_mode  = rom_wr_q;
  assign code_rom_clr_n    = clr_n_q;

endmodule

// File: doc/debug_cmd_decoder.md
DEBUG_CMD_DECODER -- requirements
Module: debug_cmd_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 16, cycles to wait for command_complete before reporting timeout.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 rx_data  input  8  host byte from serial receiver.
REQ-005 rx_valid  input  1  rx_data valid; byte consumed when rx_valid and rx_ready both high at a rising edge.
REQ-006 rx_ready  output  1  decoder can accept a byte.
REQ-007 tx_data  output  8  acknowledge byte to host.
REQ-008 tx_valid  output  1  tx_data valid; held until tx_ready.
REQ-009 tx_ready  input  1  transmitter accepts byte.
REQ-010 debug_cmd  output  4  command code to harness FSM; 0 when idle.
REQ-011 command_complete  input  1  harness done pulse.
REQ-012 code_rom_addr_out  output  12  ROM write address.
REQ-013 code_rom_data_out  output  8  ROM write data.
REQ-014 program_rom_mode  output  1  ROM write strobe.
REQ-015 code_rom_clr_n  output  1  active-low ROM clear pulse.

Function
REQ-016 The decoder SHALL parse frames: first byte opcode; 0x01 RUN, 0x02 HALT, 0x03 STEP, 0x10 PROGRAM, 0x20 CLEAR; any other value is unknown.
REQ-017 States SHALL be IDLE, ADDR_HI, ADDR_LO, LEN, DATA, ISSUE, WAIT_CMP, CLEAR, ACK.
REQ-018 rx_ready SHALL be high only in IDLE, ADDR_HI, ADDR_LO, LEN, DATA, and only when program_rom_mode is not asserted that cycle.
REQ-019 RUN/HALT/STEP: IDLE->ISSUE; debug_cmd = opcode[3:0] for exactly one cycle, then 0; ->WAIT_CMP.
REQ-020 WAIT_CMP SHALL count cycles; command_complete high -> ACK with tx_data = opcode; count reaching TIMEOUT_CYCLES first -> ACK with tx_data = 0xEF.
REQ-021 PROGRAM: ADDR_HI (bits [3:0] used as addr[11:8], upper nibble ignored), ADDR_LO (addr[7:0]), LEN (0 means 256 bytes), then DATA for LEN bytes.
REQ-022 Each consumed DATA byte SHALL produce, on the following cycle, program_rom_mode=1 for exactly one cycle with code_rom_addr_out/code_rom_data_out stable and registered.
REQ-023 Address SHALL increment by 1 after each write, wrapping 0xFFF->0x000 modulo 12 bits.
REQ-024 After the last write strobe, the FSM SHALL go to ACK with tx_data = 0x10.
REQ-025 CLEAR: code_rom_clr_n low for exactly one cycle, then ACK with tx_data = 0x20.
REQ-026 Unknown opcode: ACK with tx_data = 0xEE; no other output changes.
REQ-027 ACK: tx_valid high, tx_data stable until tx_ready high at a rising edge; next state IDLE; rx bytes during ACK SHALL not be consumed.
REQ-028 command_complete outside WAIT_CMP SHALL be ignored.
REQ-029 Minimum latency: RUN opcode consumed at cycle N -> debug_cmd valid cycle N+1.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 On reset_n low: state IDLE, rx_ready 0 until first edge after release, tx_valid 0, tx_data 0x00, debug_cmd 0, program_rom_mode 0, code_rom_addr_out 0, code_rom_data_out 0, code_rom_clr_n 1, counters 0.
REQ-032 Reset mid-frame SHALL abandon the frame with no ack and no further ROM writes.

Structure
REQ-033 Opcode constants, ack codes (0xEE, 0xEF), and the state enum SHALL live in shared package debug_pkg.
REQ-034 No sub-module; single FSM with address, length and timeout counters.

Verification
REQ-035 Send 0x01 with a harness model pulsing command_complete 2 cycles later -> debug_cmd=1 for one cycle, tx_data 0x01.
REQ-036 Send 0x10,0x0F,0xFE,0x03,0xAA,0xBB,0xCC -> three strobes at addresses 0xFFE, 0xFFF, 0x000 with data AA, BB, CC; ack 0x10.
REQ-037 Send 0x02 with command_complete never asserted -> ack 0xEF after 16 cycles in WAIT_CMP.
REQ-038 Send 0x20 -> code_rom_clr_n low for exactly one cycle; ack 0x20. Send 0x55 -> ack 0xEE with no strobes.
REQ-039 Hold tx_ready low for 10 cycles during ACK while rx_valid is high -> tx_data stable, no byte consumed.
REQ-040 Assert reset_n low after the second of four PROGRAM data bytes -> no further strobes; next frame decodes normally.
